lif_neuron_mc: RTL and testbench
================================

Name: lif_neuron_mc

Overview:
Parametrised multi-channel successor to the single-channel LIF neuron.
- Accepts one input vector per timestep over a valid/ready handshake.
- Accumulates N_CH signed-weighted channels with one time-multiplexed MAC, then applies leak, saturation, threshold and refractory logic.
- Refractory period is programmable.
- Sits between the spike-encoder/loader front end and the spike router.

Parameters:
N_CH, 4, number of input channels (>=1)
IN_BITS, 6, unsigned channel width
W_BITS, 4, signed two's-complement weight width
V_BITS, 8, membrane potential width (unsigned)
THR_STEP, 8, adaptive threshold increment (optional feature only)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  gates acceptance of new timesteps
params_ready  in  1  configuration valid; gates acceptance
in_valid  in  1  input vector valid
in_ready  out  1  block can accept a vector
chan_in  in  N_CH*IN_BITS  packed channels, ch0 in LSBs
weights  in  N_CH*W_BITS  packed signed weights, ch0 in LSBs
leak_config  in  2  00:0, 01:2, 10:4, 11:1
threshold  in  V_BITS  firing threshold
refrac_period  in  4  refractory timesteps after a spike
out_valid  out  1  one-cycle result strobe
spike_out  out  1  spike for this timestep; valid only with out_valid
v_mem_out  out  V_BITS  current membrane potential register

Behaviour:
- Reset (async, reset_n=0): state=IDLE, v_mem=0, refr_cnt=0, acc=0, ch_idx=0, out_valid=0, spike_out=0, in_ready=0. Reset mid-timestep aborts it; no out_valid is produced.
- in_ready = (state==IDLE) && enable && params_ready. A vector is accepted on an edge where in_valid && in_ready. chan_in and weights are captured on acceptance. leak_config, threshold and refrac_period are sampled during the UPDATE/LEAK cycle.
- States: IDLE, ACCUM, UPDATE, LEAK.
- IDLE, on accept:
  - refr_cnt!=0: go to LEAK.
  - Otherwise: go to ACCUM with acc=0 and ch_idx=0.
- ACCUM (N_CH cycles):
  - Each cycle: acc += chan[ch_idx] (zero-extended) * weight[ch_idx] (signed).
  - ch_idx increments; after ch_idx==N_CH-1, go to UPDATE.
  - acc is signed, ACC_W = IN_BITS+W_BITS+clog2(N_CH)+1, and never overflows.
- UPDATE (1 cycle):
  - new_v = v_mem + acc - leak, computed signed at ACC_W+1 bits, clamped to [0, 2^V_BITS-1].
  - If new_v >= thr_eff: spike_out=1, v_mem=0, refr_cnt=refrac_period.
  - Else: spike_out=0, v_mem=new_v.
  - out_valid=1; go to IDLE.
- LEAK (1 cycle): v_mem = (v_mem>leak) ? v_mem-leak : 0; refr_cnt -= 1; spike_out=0; out_valid=1; go to IDLE.
- Latency from the accepting edge to the out_valid cycle:
  - Normal timestep: N_CH+1 edges.
  - Refractory timestep: 1 edge.
  - Throughput: one vector per N_CH+2 cycles (normal) or 2 cycles (refractory).
- out_valid and spike_out are registered and high for exactly one cycle; otherwise 0.
- enable/params_ready deassert: an in-flight timestep completes normally; only new acceptance is blocked; state is held.
- threshold==0: every non-refractory timestep spikes. refrac_period==0: no refractory timesteps.

Optional Feature:
LIF_ADAPT_THRESH_EN
- Defined:
  - Adds register thr_adapt [V_BITS-1:0], reset 0.
  - On spike: thr_adapt += THR_STEP, saturating.
  - On every other completed timestep: thr_adapt decrements by 1 if nonzero.
  - thr_eff = min(threshold + thr_adapt, 2^V_BITS-1).
- Undefined: thr_eff = threshold; no thr_adapt register exists.

Decomposition:
- Package lif_pkg:
  - state enum (IDLE/ACCUM/UPDATE/LEAK)
  - leak decode constants and decode function
  - ACC_W width function
- One natural sub-module: lif_mac_seq, the sequential channel accumulator. It takes start/captured vectors and produces acc plus a done pulse.

Test Plan:
- N_CH=4, chan=10 all, weights=+2 all, leak 00, threshold 200, refrac 4. Three timesteps give v=80, 160, then spike (240>=200). out_valid comes 5 edges after accept; v_mem_out=0 afterwards.
- After that spike: 4 accepted timesteps each take the LEAK path (1-edge latency, spike 0). The 5th timestep integrates again.
- Weights=-8 all, chan=63 all, v_mem=100: acc=-2016, v clamps to 0, no spike.
- Weights=+7 all, chan=63 all, threshold 255: acc=1764, v saturates at 255, spike fires.
- Assert reset_n low during ACCUM: all registers go 0 immediately and no out_valid appears. With enable=0, in_ready stays 0 while in_valid=1.
- LIF_ADAPT_THRESH_EN, THR_STEP=8, threshold 100, constant drive acc=100, leak 00, refrac 0: first spike raises thr_eff to 108, and the next timestep (v=100) does not spike.

Source files
------------

// File: rtl/lif_pkg.sv
// -----------------------------------------------------------------------------
// lif_pkg
// Shared definitions for the multi-channel leaky integrate-and-fire neuron:
//   - state_t     : timestep sequencer states (IDLE/ACCUM/UPDATE/LEAK)
//   - LEAK_W      : width of a decoded leak amount
//   - leak_decode : 2-bit leak_config -> leak amount (00:0, 01:2, 10:4, 11:1)
//   - acc_width   : signed accumulator width that can hold N_CH worst-case
//                   products without overflow
//   - idx_width   : width of the channel index counter
// -----------------------------------------------------------------------------
package lif_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        UPDATE = 2'd2,
        LEAK   = 2'd3
    } state_t;

    localparam int LEAK_W = 3;

    localparam logic [1:0] LEAK_CFG_NONE = 2'b00;
    localparam logic [1:0] LEAK_CFG_TWO  = 2'b01;
    localparam logic [1:0] LEAK_CFG_FOUR = 2'b10;
    localparam logic [1:0] LEAK_CFG_ONE  = 2'b11;

    // The encoding is deliberately non-monotonic: 11 means a leak of 1, kept
    // for compatibility with the single-channel neuron's configuration word.
    function automatic logic [LEAK_W-1:0] leak_decode(input logic [1:0] cfg);
        logic [LEAK_W-1:0] amt;
        case (cfg)
            LEAK_CFG_NONE: amt = 3'd0;
            LEAK_CFG_TWO:  amt = 3'd2;
            LEAK_CFG_FOUR: amt = 3'd4;
            default:       amt = 3'd1;
        endcase
        return amt;
    endfunction

    // One product needs IN_BITS+W_BITS signed bits; summing N_CH of them adds
    // clog2(N_CH) bits, plus one bit of headroom.
    function automatic int acc_width(input int in_bits, input int w_bits, input int n_ch);
        return in_bits + w_bits + $clog2(n_ch) + 1;
    endfunction

    function automatic int idx_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/lif_neuron_mc_mac.sv
// -----------------------------------------------------------------------------
// lif_mac_seq
// Sequential multiply-accumulate over N_CH channels using one multiplier.
// A start pulse clears the accumulator and index; on each following cycle one
// channel (zero-extended) times its signed weight is added, ch0 first.
//
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   start         : clear acc/index and begin a new accumulation
//   chan_vec      : packed unsigned channels, ch0 in LSBs (held stable)
//   weight_vec    : packed signed weights, ch0 in LSBs (held stable)
//   acc           : running signed sum
//   done          : high during the cycle that adds the last channel, so the
//                   full sum is in acc on the following cycle
// -----------------------------------------------------------------------------
module lif_mac_seq
    import lif_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int IN_BITS = 6,
    parameter int W_BITS  = 4,
    parameter int ACC_W   = acc_width(IN_BITS, W_BITS, N_CH)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [N_CH*IN_BITS-1:0]     chan_vec,
    input  logic [N_CH*W_BITS-1:0]      weight_vec,
    output logic signed [ACC_W-1:0]     acc,
    output logic                        done
);

    localparam int IDX_W = idx_width(N_CH);

    logic [IDX_W-1:0]          ch_idx;
    logic                      busy;
    logic [IN_BITS-1:0]        chan_sel;
    logic [W_BITS-1:0]         weight_sel;
    logic signed [ACC_W-1:0]   chan_ext;
    logic signed [ACC_W-1:0]   weight_ext;
    logic signed [ACC_W-1:0]   product;

    // Channel/weight multiplexer driven by the current index.
    always_comb begin
        chan_sel   = '0;
        weight_sel = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_idx == IDX_W'(i)) begin
                chan_sel   = chan_vec[i*IN_BITS +: IN_BITS];
                weight_sel = weight_vec[i*W_BITS +: W_BITS];
            end
        end
    end

    // Channels are unsigned, weights two's complement; both are widened to
    // the accumulator width before the multiply so the product is exact.
    assign chan_ext   = {{(ACC_W-IN_BITS){1'b0}}, chan_sel};
    assign weight_ext = {{(ACC_W-W_BITS){weight_sel[W_BITS-1]}}, weight_sel};
    assign product    = chan_ext * weight_ext;

    assign done = busy && (ch_idx == IDX_W'(N_CH-1));

    // Accumulator, index and busy flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc    <= '0;
            ch_idx <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            ch_idx <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc <= acc + product;
            if (done) begin
                busy   <= 1'b0;
                ch_idx <= '0;
            end else begin
                ch_idx <= ch_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/lif_neuron_mc.sv
// -----------------------------------------------------------------------------
// lif_neuron_mc
// Multi-channel leaky integrate-and-fire neuron. One input vector is accepted
// per timestep over in_valid/in_ready. Normal timesteps accumulate the
// weighted channels in lif_mac_seq (N_CH cycles) and then update the membrane
// (leak, clamp, threshold). While refractory, a timestep only leaks the
// membrane and counts the refractory period down.
//
// Optional build macro: LIF_ADAPT_THRESH_EN adds an adaptive threshold
// register (thr_adapt) that rises by THR_STEP on each spike and decays by 1
// on every other completed timestep.
//
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   enable         : gates acceptance of new timesteps
//   params_ready   : configuration valid; gates acceptance
//   in_valid       : input vector valid
//   in_ready       : block can accept a vector
//   chan_in        : packed unsigned channels, ch0 in LSBs
//   weights        : packed signed weights, ch0 in LSBs
//   leak_config    : 00:0, 01:2, 10:4, 11:1
//   threshold      : firing threshold
//   refrac_period  : refractory timesteps following a spike
//   out_valid      : one-cycle result strobe
//   spike_out      : spike for this timestep, valid with out_valid
//   v_mem_out      : membrane potential register
// -----------------------------------------------------------------------------
module lif_neuron_mc
    import lif_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int IN_BITS = 6,
    parameter int W_BITS  = 4,
    parameter int V_BITS  = 8
`ifdef LIF_ADAPT_THRESH_EN
    ,
    parameter int THR_STEP = 8
`endif
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      params_ready,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_CH*IN_BITS-1:0]   chan_in,
    input  logic [N_CH*W_BITS-1:0]    weights,
    input  logic [1:0]                leak_config,
    input  logic [V_BITS-1:0]         threshold,
    input  logic [3:0]                refrac_period,
    output logic                      out_valid,
    output logic                      spike_out,
    output logic [V_BITS-1:0]         v_mem_out
);

    localparam int ACC_W = acc_width(IN_BITS, W_BITS, N_CH);
    // Wide enough for v_mem + acc - leak to be exact and carry a sign bit.
    localparam int SUM_W = ((ACC_W > V_BITS + 1) ? ACC_W : V_BITS + 1) + 1;
    localparam logic [V_BITS-1:0] V_MAX = '1;

    state_t                    state;
    state_t                    next_state;
    logic [V_BITS-1:0]         v_mem;
    logic [V_BITS-1:0]         v_next;
    logic [3:0]                refr_cnt;
    logic [3:0]                refr_next;
    logic                      out_valid_next;
    logic                      spike_next;
    logic [N_CH*IN_BITS-1:0]   chan_reg;
    logic [N_CH*W_BITS-1:0]    weight_reg;

    logic                      accept;
    logic                      mac_start;
    logic                      mac_done;
    logic signed [ACC_W-1:0]   acc;

    logic [LEAK_W-1:0]         leak_amt;
    logic [V_BITS-1:0]         leak_v;
    logic signed [SUM_W-1:0]   sum_wide;
    logic [V_BITS-1:0]         new_v;
    logic [V_BITS-1:0]         thr_eff;
    logic                      fire;

    // in_ready is forced low while reset is held, even though state is IDLE.
    assign in_ready  = reset_n && (state == IDLE) && enable && params_ready;
    assign accept    = in_valid && in_ready;
    assign mac_start = accept && (refr_cnt == 4'd0);
    assign leak_amt  = leak_decode(leak_config);
    assign leak_v    = V_BITS'(leak_amt);
    assign v_mem_out = v_mem;

    lif_mac_seq #(
        .N_CH    (N_CH),
        .IN_BITS (IN_BITS),
        .W_BITS  (W_BITS),
        .ACC_W   (ACC_W)
    ) u_mac (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (mac_start),
        .chan_vec   (chan_reg),
        .weight_vec (weight_reg),
        .acc        (acc),
        .done       (mac_done)
    );

    // Candidate membrane value: signed sum, then clamped into [0, V_MAX].
    always_comb begin
        sum_wide = $signed({{(SUM_W-V_BITS){1'b0}}, v_mem})
                 + $signed({{(SUM_W-ACC_W){acc[ACC_W-1]}}, acc})
                 - $signed({{(SUM_W-LEAK_W){1'b0}}, leak_amt});
        if (sum_wide[SUM_W-1]) begin
            new_v = '0;
        end else if (sum_wide[SUM_W-2:V_BITS] != '0) begin
            new_v = V_MAX;
        end else begin
            new_v = sum_wide[V_BITS-1:0];
        end
    end

`ifdef LIF_ADAPT_THRESH_EN
    localparam int VB1 = V_BITS + 1;

    logic [V_BITS-1:0] thr_adapt;
    logic [V_BITS-1:0] thr_adapt_next;
    logic [V_BITS-1:0] thr_up;
    logic [V_BITS-1:0] thr_down;
    logic [V_BITS:0]   thr_sum;
    logic [V_BITS:0]   step_sum;

    // Effective threshold and the saturating up/down adaptation values.
    always_comb begin
        thr_sum  = {1'b0, threshold} + {1'b0, thr_adapt};
        thr_eff  = thr_sum[V_BITS] ? V_MAX : thr_sum[V_BITS-1:0];
        step_sum = {1'b0, thr_adapt} + VB1'(THR_STEP);
        thr_up   = step_sum[V_BITS] ? V_MAX : step_sum[V_BITS-1:0];
        thr_down = (thr_adapt != '0) ? thr_adapt - V_BITS'(1) : '0;
    end
`else
    assign thr_eff = threshold;
`endif

    assign fire = (new_v >= thr_eff);

    // Next-state and next-register logic for the timestep sequencer.
    always_comb begin
        next_state     = state;
        v_next         = v_mem;
        refr_next      = refr_cnt;
        out_valid_next = 1'b0;
        spike_next     = 1'b0;
`ifdef LIF_ADAPT_THRESH_EN
        thr_adapt_next = thr_adapt;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (refr_cnt != 4'd0) ? LEAK : ACCUM;
                end
            end
            ACCUM: begin
                if (mac_done) begin
                    next_state = UPDATE;
                end
            end
            UPDATE: begin
                out_valid_next = 1'b1;
                next_state     = IDLE;
                if (fire) begin
                    spike_next = 1'b1;
                    v_next     = '0;
                    refr_next  = refrac_period;
`ifdef LIF_ADAPT_THRESH_EN
                    thr_adapt_next = thr_up;
`endif
                end else begin
                    v_next = new_v;
`ifdef LIF_ADAPT_THRESH_EN
                    thr_adapt_next = thr_down;
`endif
                end
            end
            LEAK: begin
                out_valid_next = 1'b1;
                next_state     = IDLE;
                v_next         = (v_mem > leak_v) ? v_mem - leak_v : '0;
                refr_next      = refr_cnt - 4'd1;
`ifdef LIF_ADAPT_THRESH_EN
                thr_adapt_next = thr_down;
`endif
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State and datapath registers; input vectors are captured on accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            v_mem      <= '0;
            refr_cnt   <= '0;
            out_valid  <= 1'b0;
            spike_out  <= 1'b0;
            chan_reg   <= '0;
            weight_reg <= '0;
`ifdef LIF_ADAPT_THRESH_EN
            thr_adapt  <= '0;
`endif
        end else begin
            state      <= next_state;
            v_mem      <= v_next;
            refr_cnt   <= refr_next;
            out_valid  <= out_valid_next;
            spike_out  <= spike_next;
`ifdef LIF_ADAPT_THRESH_EN
            thr_adapt  <= thr_adapt_next;
`endif
            if (accept) begin
                chan_reg   <= chan_in;
                weight_reg <= weights;
            end
        end
    end

endmodule

// File: tb/tb_lif_neuron_mc.sv
// -----------------------------------------------------------------------------
// tb_lif_neuron_mc
// Self-checking bench for lif_neuron_mc with default parameters (N_CH=4,
// IN_BITS=6, W_BITS=4, V_BITS=8). A table of timesteps with hand-computed
// latency/spike/membrane values is applied in order, plus hand-written
// sequences for reset, acceptance gating and mid-timestep reset. With
// LIF_ADAPT_THRESH_EN defined the adaptive-threshold sequence replaces the
// table, whose expectations assume a fixed threshold.
// -----------------------------------------------------------------------------
module tb_lif_neuron_mc;

    localparam int N_CH    = 4;
    localparam int IN_BITS = 6;
    localparam int W_BITS  = 4;
    localparam int V_BITS  = 8;
    localparam int CW      = N_CH * IN_BITS;
    localparam int WW      = N_CH * W_BITS;

    logic              clk;
    logic              reset_n;
    logic              enable;
    logic              params_ready;
    logic              in_valid;
    logic              in_ready;
    logic [CW-1:0]     chan_in;
    logic [WW-1:0]     weights;
    logic [1:0]        leak_config;
    logic [V_BITS-1:0] threshold;
    logic [3:0]        refrac_period;
    logic              out_valid;
    logic              spike_out;
    logic [V_BITS-1:0] v_mem_out;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [CW-1:0]     chan;
        logic [WW-1:0]     w;
        logic [1:0]        leak;
        logic [V_BITS-1:0] thr;
        logic [3:0]        refr;
        int                lat;
        logic              spk;
        logic [V_BITS-1:0] v;
    } vec_t;

    vec_t tbl[16];

    lif_neuron_mc #(
        .N_CH    (N_CH),
        .IN_BITS (IN_BITS),
        .W_BITS  (W_BITS),
        .V_BITS  (V_BITS)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .params_ready  (params_ready),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .chan_in       (chan_in),
        .weights       (weights),
        .leak_config   (leak_config),
        .threshold     (threshold),
        .refrac_period (refrac_period),
        .out_valid     (out_valid),
        .spike_out     (spike_out),
        .v_mem_out     (v_mem_out)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CW-1:0] splat_c(input logic [IN_BITS-1:0] x);
        return {N_CH{x}};
    endfunction

    function automatic logic [WW-1:0] splat_w(input logic [W_BITS-1:0] x);
        return {N_CH{x}};
    endfunction

    function automatic vec_t mk(input logic [CW-1:0] c, input logic [WW-1:0] w,
                                input logic [1:0] lk, input logic [V_BITS-1:0] th,
                                input logic [3:0] rp, input int lat,
                                input logic spk, input logic [V_BITS-1:0] v);
        vec_t r;
        r.chan = c;  r.w = w;  r.leak = lk;  r.thr = th;  r.refr = rp;
        r.lat = lat; r.spk = spk; r.v = v;
        return r;
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Presents one vector, waits (bounded) for acceptance, then counts edges
    // until out_valid. Returns latency (-1 on timeout), spike and membrane.
    task automatic applyStimulus(input logic [CW-1:0] c, input logic [WW-1:0] w,
                                 input logic [1:0] lk, input logic [V_BITS-1:0] th,
                                 input logic [3:0] rp, input bit drop_en,
                                 output int lat, output logic spk,
                                 output logic [V_BITS-1:0] v);
        int waitc;
        @(negedge clk);
        chan_in       = c;
        weights       = w;
        leak_config   = lk;
        threshold     = th;
        refrac_period = rp;
        in_valid      = 1'b1;
        waitc         = 0;
        while (!in_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout: in_ready stayed 0, required 1");
            in_valid = 1'b0;
            lat = -1;
            spk = 1'b0;
            v   = '0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (drop_en) enable = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        spk = spike_out;
        v   = v_mem_out;
    endtask

    initial begin
        int               lat;
        logic             spk;
        logic [V_BITS-1:0] v;
        int               seen;

        // Directed timestep table (executed in order; state carries over).
        tbl[0]  = mk(splat_c(6'd10), splat_w(4'd2), 2'b00, 8'd200, 4'd4, 5, 1'b0, 8'd80);
        tbl[1]  = mk(splat_c(6'd10), splat_w(4'd2), 2'b00, 8'd200, 4'd4, 5, 1'b0, 8'd160);
        tbl[2]  = mk(splat_c(6'd10), splat_w(4'd2), 2'b00, 8'd200, 4'd4, 5, 1'b1, 8'd0);
        tbl[3]  = mk(splat_c(6'd10), splat_w(4'd2), 2'b00, 8'd200, 4'd4, 1, 1'b0, 8'd0);
        tbl[4]  = mk(splat_c(6'd10), splat_w(4'd2), 2'b00, 8'd200, 4'd4, 1, 1'b0, 8'd0);
        tbl[5]  = mk(splat_c(6'd10), splat_w(4'd2), 2'b00, 8'd200, 4'd4, 1, 1'b0, 8'd0);
        tbl[6]  = mk(splat_c(6'd10), splat_w(4'd2), 2'b00, 8'd200, 4'd4, 1, 1'b0, 8'd0);
        tbl[7]  = mk(splat_c(6'd10), splat_w(4'd2), 2'b01, 8'd200, 4'd4, 5, 1'b0, 8'd78);
        tbl[8]  = mk(CW'(11),        splat_w(4'd2), 2'b00, 8'd200, 4'd4, 5, 1'b0, 8'd100);
        tbl[9]  = mk(splat_c(6'd63), splat_w(4'h8), 2'b00, 8'd200, 4'd4, 5, 1'b0, 8'd0);
        tbl[10] = mk(splat_c(6'd63), splat_w(4'd7), 2'b00, 8'd255, 4'd0, 5, 1'b1, 8'd0);
        tbl[11] = mk('0,             '0,            2'b00, 8'd0,   4'd2, 5, 1'b1, 8'd0);
        tbl[12] = mk('0,             '0,            2'b00, 8'd0,   4'd2, 1, 1'b0, 8'd0);
        tbl[13] = mk('0,             '0,            2'b00, 8'd0,   4'd2, 1, 1'b0, 8'd0);
        tbl[14] = mk(splat_c(6'd5),  splat_w(4'd1), 2'b11, 8'd100, 4'd2, 5, 1'b0, 8'd19);
        tbl[15] = mk('0,             '0,            2'b10, 8'd100, 4'd2, 5, 1'b0, 8'd15);

        reset_n       = 1'b0;
        enable        = 1'b1;
        params_ready  = 1'b1;
        in_valid      = 1'b0;
        chan_in       = '0;
        weights       = '0;
        leak_config   = 2'b00;
        threshold     = 8'd200;
        refrac_period = 4'd4;

        // Reset values, with in_ready held low by reset.
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_spike", spike_out, 0);
        checkOutput("rst_v_mem", v_mem_out, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checkOutput("ready_after_rst", in_ready, 1);

        // enable=0 and params_ready=0 each block acceptance.
        @(negedge clk);
        enable   = 1'b0;
        in_valid = 1'b1;
        chan_in  = splat_c(6'd10);
        weights  = splat_w(4'd2);
        seen     = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checkOutput("en0_in_ready", in_ready, 0);
            if (out_valid) seen++;
        end
        @(negedge clk);
        enable       = 1'b1;
        params_ready = 1'b0;
        #1;
        checkOutput("pr0_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        if (out_valid) seen++;
        checkOutput("blocked_no_out_valid", seen, 0);
        @(negedge clk);
        in_valid     = 1'b0;
        params_ready = 1'b1;

        // In-flight timestep completes after enable is dropped.
        applyStimulus(splat_c(6'd10), splat_w(4'd2), 2'b00, 8'd200, 4'd4, 1'b1, lat, spk, v);
        checkOutput("endrop_lat", lat, 5);
        checkOutput("endrop_spike", spk, 0);
        checkOutput("endrop_v", v, 80);
        checkOutput("endrop_in_ready", in_ready, 0);
        enable = 1'b1;

        // Reset during ACCUM aborts the timestep with no out_valid.
        @(negedge clk);
        chan_in  = splat_c(6'd10);
        weights  = splat_w(4'd2);
        in_valid = 1'b1;
        #1;
        checkOutput("midrst_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_v_mem", v_mem_out, 0);
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_in_ready", in_ready, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checkOutput("midrst_no_strobe", seen, 0);
        applyStimulus(splat_c(6'd10), splat_w(4'd2), 2'b00, 8'd200, 4'd4, 1'b0, lat, spk, v);
        checkOutput("postrst_lat", lat, 5);
        checkOutput("postrst_v", v, 80);

        // Clean reset before the main sequence.
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

`ifndef LIF_ADAPT_THRESH_EN
        for (int i = 0; i < 16; i++) begin
            applyStimulus(tbl[i].chan, tbl[i].w, tbl[i].leak, tbl[i].thr, tbl[i].refr,
                          1'b0, lat, spk, v);
            checkOutput($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
            checkOutput($sformatf("vec%0d_spike", i), spk, tbl[i].spk);
            checkOutput($sformatf("vec%0d_v_mem", i), v, tbl[i].v);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_strobe_width", i), out_valid, 0);
        end
`else
        // Adaptive threshold: acc=100 each step, threshold 100, step 8.
        applyStimulus(splat_c(6'd25), splat_w(4'd1), 2'b00, 8'd100, 4'd0, 1'b0, lat, spk, v);
        checkOutput("adapt1_lat", lat, 5);
        checkOutput("adapt1_spike", spk, 1);
        checkOutput("adapt1_v", v, 0);
        applyStimulus(splat_c(6'd25), splat_w(4'd1), 2'b00, 8'd100, 4'd0, 1'b0, lat, spk, v);
        checkOutput("adapt2_spike", spk, 0);
        checkOutput("adapt2_v", v, 100);
        applyStimulus(splat_c(6'd25), splat_w(4'd1), 2'b00, 8'd100, 4'd0, 1'b0, lat, spk, v);
        checkOutput("adapt3_spike", spk, 1);
        checkOutput("adapt3_v", v, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
